// File: rtl/alu_exec_unit.sv
// alu_exec_unit: ALU control decode, ALU and PC adders with one registered output stage
module alu_exec_unit #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [1:0]            alu_op,
  input  logic [9:0]            opcode_field,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] branch_offset,
  output logic                  out_valid,
  output logic [3:0]            alu_ctrl,
  output logic [DATA_WIDTH-1:0] alu_result,
  output logic                  zero,
  output logic [DATA_WIDTH-1:0] pc_plus4,
  output logic [DATA_WIDTH-1:0] branch_target
);
  logic [3:0]            r_ctrl, ctrl;
  logic [DATA_WIDTH-1:0] res;
  always_comb begin
    r_ctrl = opcode_field == 10'b1100101100 ? 4'b0110 :
             opcode_field == 10'b1000101000 ? 4'b0000 :
             opcode_field == 10'b1010101000 ? 4'b0001 : 4'b0010;
    ctrl   = alu_op == 2'b01 ? 4'b0111 : alu_op == 2'b10 ? r_ctrl : 4'b0010;
    res    = ctrl == 4'b0000 ? operand_a & operand_b :
             ctrl == 4'b0001 ? operand_a | operand_b :
             ctrl == 4'b0010 ? operand_a + operand_b :
             ctrl == 4'b0110 ? operand_a - operand_b :
             ctrl == 4'b0111 ? operand_b :
             ctrl == 4'b1100 ? ~(operand_a | operand_b) : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid     <= 1'b0;
      alu_ctrl      <= '0;
      alu_result    <= '0;
      zero          <= 1'b0;
      pc_plus4      <= '0;
      branch_target <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        alu_ctrl      <= ctrl;
        alu_result    <= res;
        zero          <= res == '0;
        pc_plus4      <= pc + DATA_WIDTH'(4);
        branch_target <= pc + branch_offset;
      end
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: random stimulus against a behavioural model, plus directed literal checks
module tb_alu_exec_unit;
  localparam int W = 64;
  logic         clk = 0, reset, in_valid;
  logic [1:0]   alu_op;
  logic [9:0]   opcode_field;
  logic [W-1:0] operand_a, operand_b, pc, branch_offset;
  logic         out_valid, zero;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] alu_result, pc_plus4, branch_target;
  int errors = 0, checks = 0;

  alu_exec_unit #(.DATA_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .alu_op(alu_op),
    .opcode_field(opcode_field), .operand_a(operand_a), .operand_b(operand_b),
    .pc(pc), .branch_offset(branch_offset), .out_valid(out_valid),
    .alu_ctrl(alu_ctrl), .alu_result(alu_result), .zero(zero),
    .pc_plus4(pc_plus4), .branch_target(branch_target)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] m_ctrl(input logic [1:0] op, input logic [9:0] fn);
    if (op == 2'd1) return 4'd7;
    if (op != 2'd2) return 4'd2;
    if (fn == 10'h32C) return 4'd6;
    if (fn == 10'h228) return 4'd0;
    if (fn == 10'h2A8) return 4'd1;
    return 4'd2;
  endfunction

  function automatic logic [W-1:0] m_alu(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] wide;
    case (c)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: begin wide = {1'b0, a} + {1'b0, b}; return wide[W-1:0]; end
      4'd6: begin wide = {1'b0, a} + {1'b0, ~b} + 1; return wide[W-1:0]; end
      4'd7: return b;
      4'd12: return ~(a | b);
      default: return '0;
    endcase
  endfunction

  logic         e_valid = 0, e_zero = 0;
  logic [3:0]   e_ctrl = 0;
  logic [W-1:0] e_res = 0, e_p4 = 0, e_bt = 0;

  always @(posedge clk) begin
    if (reset) begin
      e_valid = 0; e_ctrl = 0; e_res = 0; e_zero = 0; e_p4 = 0; e_bt = 0;
    end else begin
      e_valid = in_valid;
      if (in_valid) begin
        e_ctrl = m_ctrl(alu_op, opcode_field);
        e_res  = m_alu(e_ctrl, operand_a, operand_b);
        e_zero = (e_res == 0);
        e_p4   = pc + 64'd4;
        e_bt   = pc + branch_offset;
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m_valid", W'(out_valid), W'(e_valid));
    chk("m_ctrl", W'(alu_ctrl), W'(e_ctrl));
    chk("m_result", alu_result, e_res);
    chk("m_zero", W'(zero), W'(e_zero));
    chk("m_pc4", pc_plus4, e_p4);
    chk("m_btgt", branch_target, e_bt);
  end

  task automatic step(input logic rst, input logic v, input logic [1:0] op, input logic [9:0] fn,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] p, input logic [W-1:0] off);
    reset = rst; in_valid = v; alu_op = op; opcode_field = fn;
    operand_a = a; operand_b = b; pc = p; branch_offset = off;
    @(negedge clk);
  endtask

  initial begin
    step(1, 1, 2'd2, 10'h32C, 5, 9, 64'h100, 64'h20);
    chk("rst_valid", W'(out_valid), 0);
    chk("rst_result", alu_result, 0);
    chk("rst_ctrl", W'(alu_ctrl), 0);
    chk("rst_pc4", pc_plus4, 0);
    chk("rst_zero", W'(zero), 0);
    step(0, 1, 2'd2, 10'h32C, 5, 5, 64'h100, 64'h20);
    chk("sub_ctrl", W'(alu_ctrl), 6);
    chk("sub_result", alu_result, 0);
    chk("sub_zero", W'(zero), 1);
    chk("sub_valid", W'(out_valid), 1);
    chk("pc4_0x100", pc_plus4, 64'h104);
    chk("btgt_0x120", branch_target, 64'h120);
    step(0, 1, 2'd2, 10'h22C, '1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 8);
    chk("wrap_result", alu_result, 0);
    chk("wrap_zero", W'(zero), 1);
    chk("wrap_pc4", pc_plus4, 0);
    chk("wrap_btgt", branch_target, 4);
    step(0, 1, 2'd1, 10'h0, 7, 0, 0, 0);
    chk("passb_ctrl", W'(alu_ctrl), 7);
    chk("passb0_zero", W'(zero), 1);
    step(0, 1, 2'd1, 10'h0, 7, 3, 0, 0);
    chk("passb3_result", alu_result, 3);
    chk("passb3_zero", W'(zero), 0);
    step(0, 1, 2'd2, 10'h228, 64'hF0, 64'h3C, 0, 0);
    chk("and_result", alu_result, 64'h30);
    step(0, 1, 2'd2, 10'h2A8, 64'hF0, 64'h0F, 0, 0);
    chk("orr_result", alu_result, 64'hFF);
    chk("orr_ctrl", W'(alu_ctrl), 1);
    step(0, 0, 2'd0, 10'h0, 1, 1, 64'h500, 1);
    chk("hold_valid", W'(out_valid), 0);
    chk("hold_result", alu_result, 64'hFF);
    chk("hold_ctrl", W'(alu_ctrl), 1);
    step(0, 1, 2'd0, 10'h0, 10, 20, 0, 0);
    chk("ldst_result", alu_result, 30);
    step(0, 1, 2'd3, 10'h32C, 1, 2, 0, 0);
    chk("imm_result", alu_result, 3);
    step(0, 1, 2'd2, 10'h000, 3, 4, 0, 0);
    chk("rdef_result", alu_result, 7);
    for (int i = 0; i < 3000; i++) begin
      logic [9:0] fn;
      logic [W-1:0] a, b, p;
      case ($urandom_range(0, 4))
        0: fn = 10'h22C; 1: fn = 10'h32C; 2: fn = 10'h228; 3: fn = 10'h2A8;
        default: fn = 10'($urandom);
      endcase
      a = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: b = a; 1: b = 0; 2: b = '1; default: b = {$urandom, $urandom};
      endcase
      p = ($urandom_range(0, 7) == 0) ? {32'hFFFF_FFFF, 32'hFFFF_FFF0 | 32'($urandom_range(0, 15))} : {$urandom, $urandom};
      step($urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0, 2'($urandom), fn, a, b, p, {$urandom, $urandom});
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001: Parameter DATA_WIDTH, default 64, datapath width of operands, results and PC values.
REQ-002: One clock; reset is synchronous and active-high.
REQ-003: clk  input  1  rising-edge clock; all state updates on this edge.
REQ-004: reset  input  1  synchronous, active-high reset.
REQ-005: in_valid  input  1  qualifies all data inputs this cycle.
REQ-006: alu_op  input  2  ALU operation class from main control.
REQ-007: opcode_field  input  10  instruction bits [31:22], R-type function select.
REQ-008: operand_a  input  DATA_WIDTH  first ALU operand (register read data 1).
REQ-009: operand_b  input  DATA_WIDTH  second ALU operand (register data 2 or immediate).
REQ-010: pc  input  DATA_WIDTH  current program counter.
REQ-011: branch_offset  input  DATA_WIDTH  pre-shifted branch offset.
REQ-012: out_valid  output  1  registered results valid.
REQ-013: alu_ctrl  output  4  registered decoded ALU control code.
REQ-014: alu_result  output  DATA_WIDTH  registered ALU result.
REQ-015: zero  output  1  registered flag, 1 when alu_result is all zeros.
REQ-016: pc_plus4  output  DATA_WIDTH  registered pc + 4.
REQ-017: branch_target  output  DATA_WIDTH  registered pc + branch_offset.

Function
REQ-018: ALU control decode SHALL be combinational from alu_op and opcode_field:
- alu_op 00 -> 0010 (ADD, load/store address)
- alu_op 01 -> 0111 (PASS B, compare-and-branch)
- alu_op 10 -> decode of opcode_field per REQ-019
- alu_op 11 -> 0010 (ADD, immediate arithmetic)
REQ-019: R-type decode of opcode_field:
- 1000101100 -> 0010 ADD
- 1100101100 -> 0110 SUB
- 1000101000 -> 0000 AND
- 1010101000 -> 0001 ORR
- any other value -> 0010 ADD
REQ-020: ALU operations on alu_ctrl:
- 0000 A AND B
- 0001 A OR B
- 0010 A + B
- 0110 A - B
- 0111 B
- 1100 NOT (A OR B)
- any other code -> result 0
REQ-021: Add and subtract SHALL be unsigned modulo 2^DATA_WIDTH; carry and borrow are discarded, no overflow flag.
REQ-022: zero SHALL be 1 iff the ALU result is 0 for every operation, including PASS B.
REQ-023: pc_plus4 = pc + 4 and branch_target = pc + branch_offset, both modulo 2^DATA_WIDTH with wrap-around.
REQ-024: Latency SHALL be exactly 1 cycle: when in_valid=1 at edge N, all outputs reflect those inputs after edge N and out_valid=1.
REQ-025: When in_valid=0 at an edge, out_valid SHALL go 0 and all other outputs SHALL hold their previous values.
REQ-026: There is no backpressure; a new input may be accepted every cycle.

Reset
REQ-027: With reset=1 at a rising edge, out_valid, alu_ctrl, alu_result, pc_plus4 and branch_target SHALL become 0, and zero SHALL become 0.
REQ-028: Reset SHALL override in_valid in the same cycle; inputs presented during reset are discarded.
REQ-029: Outputs SHALL NOT change asynchronously when reset asserts between clock edges.

Verification
REQ-030: Reset for 1 cycle with in_valid=1 -> all outputs 0 and out_valid=0 after the edge.
REQ-031: alu_op=10, opcode=1100101100, A=5, B=5 -> alu_ctrl=0110, result=0, zero=1, out_valid=1 one cycle later.
REQ-032: alu_op=10, opcode=1000101100, A=FFFF_FFFF_FFFF_FFFF, B=1 -> result=0, zero=1 (wrap-around).
REQ-033: alu_op=01, A=7, B=0 -> alu_ctrl=0111, result=0, zero=1; then B=3 -> result=3, zero=0.
REQ-034: pc=0x100, branch_offset=0x20 -> pc_plus4=0x104, branch_target=0x120; pc=FFFF_FFFF_FFFF_FFFC -> pc_plus4=0.
REQ-035: Back-to-back inputs, then in_valid=0 -> results pipeline one per cycle, then out_valid=0 with the last results held.
